// File: rtl/sram_controller.sv
// Multi-cycle SRAM access controller: holds the SRAM bus for WAIT_CYCLES clocks
// per CPU load/store and stalls the pipeline through ready until the access ends.
//   state  | meaning
//   IDLE   | no access in flight; accepts wr_en/rd_en
//   ACCESS | SRAM bus held for WAIT_CYCLES cycles with latched request
//   DONE   | one-cycle completion, ready high, read data already captured
module sram_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        SRAM_WE_N,
  output logic [18:0] SRAM_Addr,
  inout  wire  [31:0] SRAM_DQ
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [31:0] wdata_q;
  logic [18:0] word_addr;
  logic        request;
  logic        drive_bus;

  // Modulo-2^32 offset from BASE_ADDR; addresses below the base simply wrap.
  assign word_addr = 19'((address - BASE_ADDR) >> 2);
  assign request   = wr_en | rd_en;
  assign drive_bus = (state == ACCESS) && op_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      wdata_q   <= 32'd0;
      read_data <= 32'd0;
      SRAM_Addr <= 19'd0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            SRAM_Addr <= word_addr;
            wdata_q   <= write_data;
            op_wr     <= wr_en;
            cnt       <= 4'd0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
            if (!op_wr) read_data <= SRAM_DQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == DONE) || ((state == IDLE) && !request);
  assign SRAM_WE_N = !drive_bus;
  assign SRAM_DQ   = drive_bus ? wdata_q : 32'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: the driver queues expected completions,
// a negedge monitor checks latency, bus activity, address and read data.
module tb_sram_controller;

  typedef struct {
    logic [18:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_we_n;
  logic [18:0] sram_addr;
  wire  [31:0] dq;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  logic [31:0] mem [0:7];
  logic [31:0] model_word;
  logic        model_drive;

  sram_controller #(.WAIT_CYCLES(5), .BASE_ADDR(32'd1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_Addr  (sram_addr),
    .SRAM_DQ    (dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small aliased SRAM model; drives the bus only while a read-side access is pending.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
  end
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[2:0]] <= dq;
  end
  assign model_word  = mem[sram_addr[2:0]];
  assign model_drive = sram_we_n && !ready;
  assign dq = model_drive ? model_word : 32'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [18:0] exp_addr,
                        input logic [31:0] exp_rd, input bit toggle);
    bit done;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    sb.push_back('{addr: exp_addr, wr: wr, wdata: d, rdata: exp_rd});
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (toggle && i == 1) begin
        wr_en = ~wr;
        rd_en = ~rd;
        address = 32'd2000;
        write_data = 32'h0;
      end
      if (ready) done = 1;
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_req();
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = 32'd0;
    write_data = 32'd0;
  endtask

  // Monitor: completion is the cycle ready rises after a stall.
  initial begin : monitor
    bit prev_ready;
    int low_cnt;
    int we_cnt;
    exp_t e;
    prev_ready = 1;
    low_cnt = 0;
    we_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ready = 1;
        low_cnt = 0;
        we_cnt = 0;
      end else begin
        if (!sram_we_n) begin
          we_cnt++;
          if (sb.size() > 0) chk("dq_write", dq, sb[0].wdata);
        end
        if (!ready) low_cnt++;
        if (ready && !prev_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("latency", 32'(low_cnt), 32'd6);
            chk("we_low_cycles", 32'(we_cnt), e.wr ? 32'd5 : 32'd0);
            chk("we_n_done", {31'd0, sram_we_n}, 32'd1);
            chk("sram_addr", {13'd0, sram_addr}, {13'd0, e.addr});
            chk("read_data", read_data, e.rdata);
          end
          low_cnt = 0;
          we_cnt = 0;
        end
        prev_ready = ready;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1;
    release_req();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", {13'd0, sram_addr}, 32'd0);
    rst = 1'b0;

    // write, then read back, idle, unrelated write leaves read_data alone
    do_txn(1, 0, 32'd1028, 32'hDEAD_BEEF, 19'd1, 32'd0, 0);
    release_req();
    @(posedge clk); #1;
    do_txn(0, 1, 32'd1028, 32'd0, 19'd1, 32'hDEAD_BEEF, 0);
    release_req();
    @(posedge clk); #1;
    chk("hold_idle", read_data, 32'hDEAD_BEEF);
    do_txn(1, 0, 32'd1036, 32'hCAFE_F00D, 19'd3, 32'hDEAD_BEEF, 0);
    release_req();
    @(posedge clk); #1;

    // both enables: write wins
    do_txn(1, 1, 32'd1032, 32'h1234_5678, 19'd2, 32'hDEAD_BEEF, 0);
    release_req();
    @(posedge clk); #1;
    do_txn(0, 1, 32'd1032, 32'd0, 19'd2, 32'h1234_5678, 0);
    release_req();
    @(posedge clk); #1;

    // address below base wraps
    do_txn(0, 1, 32'd0, 32'd0, 19'h7FF00, 32'hA5A5_0000, 0);
    release_req();
    @(posedge clk); #1;

    // back-to-back reads with request held across DONE; low address bits ignored
    do_txn(0, 1, 32'd1031, 32'd0, 19'd1, 32'hDEAD_BEEF, 0);
    do_txn(0, 1, 32'd1031, 32'd0, 19'd1, 32'hDEAD_BEEF, 0);
    release_req();
    @(posedge clk); #1;

    // inputs changed mid-access are ignored
    do_txn(0, 1, 32'd1036, 32'd0, 19'd3, 32'hCAFE_F00D, 1);
    release_req();
    @(posedge clk); #1;

    // reset during ACCESS cycle 3 of a write
    wr_en = 1'b1;
    address = 32'd1040;
    write_data = 32'h55AA_55AA;
    repeat (3) @(posedge clk);
    #2;
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_sram_addr", {13'd0, sram_addr}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    release_req();

    // first request after release accepted on the first edge
    do_txn(0, 1, 32'd1036, 32'd0, 19'd3, 32'hCAFE_F00D, 0);
    release_req();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: WAIT_CYCLES, default 5, number of clock cycles the SRAM bus is held per access; legal range 2..15.
REQ-002 Parameter: BASE_ADDR, default 1024, CPU byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  memory-stage write request.
REQ-006 rd_en  input  1  memory-stage read request.
REQ-007 address  input  32  CPU byte address.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data, registered.
REQ-010 ready  output  1  high = no access pending or access completing this cycle; low = pipeline must stall.
REQ-011 SRAM_WE_N  output  1  SRAM write enable, active-low.
REQ-012 SRAM_Addr  output  19  SRAM word address.
REQ-013 SRAM_DQ  inout  32  SRAM data bus; driven only during write access, else high-Z.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, DONE, plus a 4-bit wait counter.
REQ-015 IDLE with (wr_en | rd_en) SHALL latch address, write_data and operation, clear the counter, and go to ACCESS.
REQ-016 IDLE with no request SHALL remain in IDLE.
REQ-017 wr_en and rd_en both high at acceptance SHALL be treated as a write; rd_en is ignored.
REQ-018 ACCESS SHALL increment the counter each cycle and go to DONE on the edge where counter == WAIT_CYCLES-1, so ACCESS lasts exactly WAIT_CYCLES cycles.
REQ-019 DONE SHALL last exactly one cycle and return to IDLE unconditionally.
REQ-020 ready SHALL be combinational: 1 in DONE; 1 in IDLE when wr_en=rd_en=0; 0 in IDLE with a request; 0 in ACCESS.
REQ-021 Request-to-ready latency SHALL be WAIT_CYCLES+1 cycles: default 6.
REQ-022 A request still asserted when the FSM returns to IDLE after DONE SHALL start a new transaction; the requester drops or changes the request in the cycle ready is high.
REQ-023 Request inputs SHALL be ignored in ACCESS and DONE; latched values SHALL be used throughout.
REQ-024 SRAM_Addr SHALL equal bits [20:2] of (latched address - BASE_ADDR), 32-bit modulo subtraction; address bits [1:0] SHALL be ignored.
REQ-025 Addresses below BASE_ADDR SHALL wrap modulo 2^32 before truncation, with no error flag.
REQ-026 SRAM_Addr SHALL hold the last latched value between accesses.
REQ-027 For writes, SRAM_WE_N SHALL be 0 during every ACCESS cycle and 1 in all other states.
REQ-028 For writes, SRAM_DQ SHALL be driven with latched write_data during every ACCESS cycle.
REQ-029 SRAM_DQ SHALL be high-Z in IDLE, DONE, and throughout reads.
REQ-030 For reads, read_data SHALL capture SRAM_DQ on the edge leaving ACCESS.
REQ-031 read_data SHALL hold that value until the next read completes; writes SHALL NOT alter read_data.

Reset
REQ-032 rst high SHALL immediately, regardless of clk, force: state IDLE, counter 0, read_data 0, SRAM_Addr 0, SRAM_WE_N 1, SRAM_DQ high-Z.
REQ-033 Reset mid-ACCESS SHALL abort the access with no completion pulse; ready follows REQ-020 from IDLE.
REQ-034 The first request after reset release SHALL be accepted on the first rising edge with rst low.

Verification
REQ-035 Write: wr_en=1, address=1028, write_data=0xDEADBEEF -> ready low 6 cycles; SRAM_Addr=1; WE_N low for 5 cycles; DQ=0xDEADBEEF for those 5 cycles; ready high in cycle 7.
REQ-036 Read-back: rd_en=1, address=1028, SRAM model returns 0xDEADBEEF -> WE_N stays 1; DQ high-Z from controller; read_data=0xDEADBEEF in the DONE cycle; read_data held through an idle cycle and a following write.
REQ-037 Both enables: wr_en=rd_en=1, address=1032, data=0x12345678 -> write performed to SRAM_Addr=2; read_data unchanged.
REQ-038 Wrap: rd_en=1, address=0 -> SRAM_Addr=0x7FF00.
REQ-039 Back-to-back requests:
- rd_en held high across DONE -> second transaction starts, ready low again the next cycle.
- request inputs toggled during ACCESS -> latched address and operation unchanged.
REQ-040 Reset mid-op: rst pulsed during ACCESS cycle 3 of a write -> WE_N=1, DQ=Z, read_data=0 immediately, before the next edge; FSM in IDLE; no ready pulse from the aborted access.
